instr_fetch: RTL

- Instruction-fetch stage sitting directly upstream of the word-addressed instruction memory (256 x 32, registered read, data on mem_rdata one cycle after mem_rstrb).
- Drives the memory address and read strobe, captures the returned word, and presents it with its PC to decode over a valid/ready handshake.
- Accepts PC redirects from execute for branches and jumps.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/instr_fetch.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  localparam logic [31:0] OPC_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam int unsigned PC_STEP    = 4;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: strobes a registered-read memory, holds the word for decode
// on a valid/ready handshake, and accepts redirects. INSTR_FETCH_HALT_ON_EBREAK_EN adds a halt state.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
`ifdef INSTR_FETCH_HALT_ON_EBREAK_EN
  logic              halted_q, halted_d;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef INSTR_FETCH_HALT_ON_EBREAK_EN
    halted_d      = halted_q;
`endif
    if (redirect_valid) begin
      // Redirect beats everything, including a same-cycle handshake in HOLD.
      pc_d          = redirect_pc & ~ADDR_W'(3);
      instr_valid_d = 1'b0;
      state_d       = FETCH;
`ifdef INSTR_FETCH_HALT_ON_EBREAK_EN
      halted_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: state_d = WAIT;
        WAIT: begin
          instr_d       = mem_rdata;
          instr_pc_d    = pc_q;
          pc_d          = pc_q + ADDR_W'(PC_STEP);
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
        HOLD: begin
          if (instr_valid_q && instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = FETCH;
`ifdef INSTR_FETCH_HALT_ON_EBREAK_EN
            if (instr_q == OPC_EBREAK) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end
`endif
          end
        end
`ifdef INSTR_FETCH_HALT_ON_EBREAK_EN
        HALTED: state_d = HALTED;
`endif
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef INSTR_FETCH_HALT_ON_EBREAK_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef INSTR_FETCH_HALT_ON_EBREAK_EN
      halted_q      <= halted_d;
`endif
    end
  end

  assign mem_addr    = pc_q;
  assign mem_rstrb   = (state_q == FETCH) && resetn;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
`ifdef INSTR_FETCH_HALT_ON_EBREAK_EN
  assign halted      = halted_q;
`else
  assign halted      = 1'b0;
`endif

endmodule
